// File: rtl/idsadc_wb_host_if.sv
// Command/response and Wishbone bus bundle for idsadc_wb_host.
//   master : view of the host block (drives cmd_ready, rsp_*, wbm_*_o)
//   slave  : view of the environment (command source, response sink and
//            Wishbone responder)
interface idsadc_wb_host_if;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;
  logic [SEL_W-1:0] cmd_sel;

  // response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DAT_W-1:0] rsp_dat;
  logic             rsp_err;

  // Wishbone classic initiator side
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [DAT_W-1:0] wbm_dat_o;
  logic             wbm_ack_i;
  logic [DAT_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/idsadc_wb_host.sv
// Wishbone classic initiator: turns one valid/ready command into one
// Wishbone read or write cycle and returns the result on a valid/ready
// response channel. Cycles without ack are aborted after TIMEOUT_CYCLES.
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   asynchronous active-high reset
//   bus        command, response and Wishbone signals (master modport)
//   txn_count  acked transactions, saturating at 16'hFFFF
//   tmo_count  timed-out transactions, saturating at 8'hFF
module idsadc_wb_host #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  idsadc_wb_host_if.master       bus,
  output logic [15:0]            txn_count,
  output logic [7:0]             tmo_count
);

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned TXN_W = 16;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned WAIT_W = 16;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 32'd1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q,     state_nxt;
  logic              cmd_ready_q, cmd_ready_nxt;
  logic              cyc_q,       cyc_nxt;
  logic              we_q,        we_nxt;
  logic [SEL_W-1:0]  sel_q,       sel_nxt;
  logic [ADR_W-1:0]  adr_q,       adr_nxt;
  logic [DAT_W-1:0]  dat_q,       dat_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic              rsp_err_q,   rsp_err_nxt;
  logic [DAT_W-1:0]  rsp_dat_q,   rsp_dat_nxt;
  logic [TXN_W-1:0]  txn_q,       txn_nxt;
  logic [TMO_W-1:0]  tmo_q,       tmo_nxt;
  logic [WAIT_W-1:0] wait_q,      wait_nxt;

  // State and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      txn_q       <= '0;
      tmo_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      cyc_q       <= cyc_nxt;
      we_q        <= we_nxt;
      sel_q       <= sel_nxt;
      adr_q       <= adr_nxt;
      dat_q       <= dat_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_dat_q   <= rsp_dat_nxt;
      txn_q       <= txn_nxt;
      tmo_q       <= tmo_nxt;
      wait_q      <= wait_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state_q;
    cmd_ready_nxt = cmd_ready_q;
    cyc_nxt       = cyc_q;
    we_nxt        = we_q;
    sel_nxt       = sel_q;
    adr_nxt       = adr_q;
    dat_nxt       = dat_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_err_nxt   = rsp_err_q;
    rsp_dat_nxt   = rsp_dat_q;
    txn_nxt       = txn_q;
    tmo_nxt       = tmo_q;
    wait_nxt      = wait_q;

    case (state_q)
      S_IDLE: begin
        // after a response, cmd_ready is re-raised one cycle into IDLE
        if (!cmd_ready_q) begin
          cmd_ready_nxt = 1'b1;
        end else if (bus.cmd_valid) begin
          cmd_ready_nxt = 1'b0;
          cyc_nxt       = 1'b1;
          we_nxt        = bus.cmd_we;
          sel_nxt       = bus.cmd_sel;
          adr_nxt       = bus.cmd_adr;
          dat_nxt       = bus.cmd_dat;
          wait_nxt      = '0;
          state_nxt     = S_BUS;
        end
      end

      S_BUS: begin
        if (bus.wbm_ack_i) begin
          // ack has priority over a coincident timeout
          cyc_nxt       = 1'b0;
          rsp_dat_nxt   = we_q ? dat_q : bus.wbm_dat_i;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          txn_nxt       = (txn_q == '1) ? txn_q : txn_q + TXN_W'(1);
          state_nxt     = S_RESP;
        end else if (wait_q == WAIT_LAST) begin
          cyc_nxt       = 1'b0;
          rsp_dat_nxt   = ERR_DATA;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          tmo_nxt       = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
          state_nxt     = S_RESP;
        end else begin
          wait_nxt = wait_q + WAIT_W'(1);
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign txn_count     = txn_q;
  assign tmo_count     = tmo_q;

endmodule

// File: tb/tb_idsadc_wb_host.sv
// Self-checking bench for idsadc_wb_host: directed scenarios plus random
// transactions against a transaction-level reference model and a memory
// backed Wishbone responder.
module tb_idsadc_wb_host;

  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic wb_clk_i;
  logic wb_rst_i;
  logic [15:0] txn_count;
  logic [7:0]  tmo_count;

  idsadc_wb_host_if bus();

  idsadc_wb_host #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (ERR)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus),
    .txn_count(txn_count),
    .tmo_count(tmo_count)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_no = 0;
  int exp_txn  = 0;
  int exp_tmo  = 0;

  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle_no);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    cycle_no++;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_txn"}, 32'(txn_count), 32'(exp_txn));
    check({tag, "_tmo"}, 32'(tmo_count), 32'(exp_tmo));
  endtask

  // One command/response exchange. ack_at: cycle of cyc on which the
  // responder acks (1 = zero wait, 0 = never). hold: cycles of rsp_ready=0.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input int hold,
                        output int acc_cyc);
    int          ncyc;
    int          exp_len;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [31:0] a;

    for (int w = 0; w < 8 && bus.cmd_ready !== 1'b1; w++) tick();
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);

    // reference: outcome of the transaction from the protocol rules
    if (ack_at >= 1 && ack_at <= TMO) begin
      exp_len = ack_at;
      exp_err = 1'b0;
      exp_dat = we ? dat : ref_rd(adr);
    end else begin
      exp_len = TMO;
      exp_err = 1'b1;
      exp_dat = ERR;
    end

    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    tick();
    acc_cyc = cycle_no;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'($urandom);
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.cmd_sel   = 4'($urandom);

    ncyc = 0;
    while (bus.wbm_cyc_o === 1'b1 && ncyc < 4 * TMO) begin
      ncyc++;
      check("bus_stb", 32'(bus.wbm_stb_o), 32'd1);
      check("bus_we",  32'(bus.wbm_we_o),  32'(we));
      check("bus_adr", bus.wbm_adr_o, adr);
      check("bus_sel", 32'(bus.wbm_sel_o), 32'(sel));
      check("bus_dat", bus.wbm_dat_o, dat);
      check("bus_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      if (ncyc == ack_at) begin
        a = bus.wbm_adr_o;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = slv_mem.exists(a) ? slv_mem[a] : 32'h0;
        if (bus.wbm_we_o)
          slv_mem[a] = merge(slv_mem.exists(a) ? slv_mem[a] : 32'h0, bus.wbm_dat_o, bus.wbm_sel_o);
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom;
      end
      tick();
    end
    bus.wbm_ack_i = 1'b0;
    check("cyc_len", 32'(ncyc), 32'(exp_len));
    check("stb_off", 32'(bus.wbm_stb_o), 32'd0);

    if (!exp_err && we) ref_mem[adr] = merge(ref_rd(adr), dat, sel);
    if (exp_err) begin
      if (exp_tmo < 255) exp_tmo++;
    end else begin
      if (exp_txn < 65535) exp_txn++;
    end

    // backpressure with stray acks and commands
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_dat", bus.rsp_dat, exp_dat);
      check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("hold_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      check_counters("hold");
      bus.wbm_ack_i = 1'($urandom);
      bus.wbm_dat_i = $urandom;
      bus.cmd_valid = 1'($urandom);
      tick();
    end
    bus.wbm_ack_i = 1'b0;
    bus.cmd_valid = 1'b0;

    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_dat", bus.rsp_dat, exp_dat);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check_counters("rsp");
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("turn_cmd_ready", 32'(bus.cmd_ready), 32'd0);

    // command offered during the turnaround cycle must be ignored
    bus.cmd_valid = 1'($urandom);
    bus.wbm_ack_i = 1'($urandom);
    tick();
    bus.cmd_valid = 1'b0;
    bus.wbm_ack_i = 1'b0;
    check("turn_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("ready_back", 32'(bus.cmd_ready), 32'd1);
    check_counters("turn");
  endtask

  int acc0, acc1;
  logic [31:0] radr;

  initial begin
    wb_rst_i      = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    tick();
    tick();

    // reset state
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("rst_we", 32'(bus.wbm_we_o), 32'd0);
    check("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
    check("rst_adr", bus.wbm_adr_o, 32'd0);
    check("rst_dat", bus.wbm_dat_o, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_dat", bus.rsp_dat, 32'd0);
    check_counters("rst");
    wb_rst_i = 1'b0;
    tick();

    // write then read, one wait state
    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 0, acc0);
    do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 0, acc0);
    check("wr_rd_txn", 32'(txn_count), 32'd2);

    // zero-wait back-to-back: 4 cycles per transaction
    do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 0, acc0);
    do_txn(1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'h3, 1, 0, acc1);
    check("throughput", 32'(acc1 - acc0), 32'd4);

    // timeout
    do_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 0, acc0);

    // ack on the last permitted cycle wins over timeout
    slv_mem[32'h3000_0010] = 32'h0000_00C3;
    ref_mem[32'h3000_0010] = 32'h0000_00C3;
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, TMO, 0, acc0);
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, TMO + 1, 0, acc0);

    // backpressure with stray ack/cmd
    do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 10, acc0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      radr = 32'h3000_0000 + 32'(4 * $urandom_range(0, 5));
      do_txn(1'($urandom), radr, $urandom, 4'($urandom), int'($urandom_range(0, TMO + 2)),
             int'($urandom_range(0, 4)), acc0);
    end

    // tmo_count saturation
    for (int i = 0; i < 258; i++)
      do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 0, acc0);
    check("tmo_sat", 32'(tmo_count), 32'hFF);

    // asynchronous reset in the middle of a bus cycle
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h3000_0004;
    bus.cmd_sel   = 4'hF;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_cyc", 32'(bus.wbm_cyc_o), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("mid_rst_adr", bus.wbm_adr_o, 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    exp_txn = 0;
    exp_tmo = 0;
    check_counters("mid_rst");
    tick();
    wb_rst_i = 1'b0;
    tick();
    do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 1, acc0);
    check("post_rst_txn", 32'(txn_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
